// File: rtl/pwm_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pwm_pkg : shared types and default sizes for the PWM generator  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package pwm_pkg;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_t;

   localparam int DEF_CHANNELS   = 4;
   localparam int DEF_WIDTH      = 8;
   localparam int DEF_PRESCALE_W = 8;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pwm_channel : double-buffered duty, comparator and output flop  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic             i_load,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_data,
   input  logic [WIDTH-1:0] i_counter,
   input  logic             i_invert,
   output logic             o_pwm
);

   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] r_active;
   logic             r_pwm;
   logic             w_raw;

   assign w_raw = (i_counter < r_active);
   assign o_pwm = r_pwm;

   // The active copy takes the shadow value from before any write on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_active <= '0;
         r_pwm    <= 1'b0;
      end else begin
         if (i_wr) begin
            r_shadow <= i_data;
         end
         if (i_load) begin
            r_active <= r_shadow;
         end
         r_pwm <= i_enable ? (w_raw ^ i_invert) : i_invert;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pwm_multi : multi-channel PWM on a shared prescaled timebase    |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int CHANNELS   = DEF_CHANNELS,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W,
   parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  center_mode,
   input  logic [WIDTH-1:0]      period,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  duty_wr,
   input  logic [CH_W-1:0]       duty_ch,
   input  logic [WIDTH-1:0]      duty_data,
   input  logic [CHANNELS-1:0]   invert,
   output logic [CHANNELS-1:0]   pwm_out,
   output logic                  period_tick
);

   localparam logic [WIDTH-1:0]      c_ONE     = 1;
   localparam logic [PRESCALE_W-1:0] c_PRE_ONE = 1;

   logic [PRESCALE_W-1:0] r_pre_cnt;
   logic [WIDTH-1:0]      r_cnt;
   logic                  r_down;
   logic [WIDTH-1:0]      r_period;
   pwm_mode_t             r_mode;
   logic                  r_period_tick;

   logic                  w_tick;
   logic                  w_boundary;
   logic                  w_load;
   logic [WIDTH-1:0]      w_cnt_nxt;
   logic                  w_down_nxt;

   // A prescale lowered below the running count wraps and ticks immediately.
   assign w_tick      = enable && (r_pre_cnt >= prescale);
   assign w_load      = !enable || w_boundary;
   assign period_tick = r_period_tick;

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_down_nxt = r_down;
      w_boundary = 1'b0;
      if (w_tick) begin
         if (r_mode == PWM_EDGE || r_period == '0) begin
            w_down_nxt = 1'b0;
            if (r_cnt >= r_period) begin
               w_cnt_nxt  = '0;
               w_boundary = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_ONE;
            end
         end else if (!r_down) begin
            if (r_cnt >= r_period) begin
               if (r_period == c_ONE) begin
                  w_cnt_nxt  = '0;
                  w_boundary = 1'b1;
               end else begin
                  w_cnt_nxt  = r_cnt - c_ONE;
                  w_down_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_ONE;
            end
         end else begin
            if (r_cnt <= c_ONE) begin
               w_cnt_nxt  = '0;
               w_down_nxt = 1'b0;
               w_boundary = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - c_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt     <= '0;
         r_cnt         <= '0;
         r_down        <= 1'b0;
         r_period      <= '0;
         r_mode        <= PWM_EDGE;
         r_period_tick <= 1'b0;
      end else if (!enable) begin
         r_pre_cnt     <= '0;
         r_cnt         <= '0;
         r_down        <= 1'b0;
         r_period      <= period;
         r_mode        <= pwm_mode_t'(center_mode);
         r_period_tick <= 1'b0;
      end else begin
         r_pre_cnt     <= w_tick ? '0 : (r_pre_cnt + c_PRE_ONE);
         r_cnt         <= w_cnt_nxt;
         r_down        <= w_down_nxt;
         r_period_tick <= w_boundary;
         if (w_boundary) begin
            r_period <= period;
            r_mode   <= pwm_mode_t'(center_mode);
         end
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic w_wr;
      assign w_wr = duty_wr && (duty_ch == CH_W'(i));

      pwm_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_enable  (enable),
         .i_load    (w_load),
         .i_wr      (w_wr),
         .i_data    (duty_data),
         .i_counter (r_cnt),
         .i_invert  (invert[i]),
         .o_pwm     (pwm_out[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_pwm_multi : scoreboard bench against a phase-based model     |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_pwm_multi;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       center_mode;
   logic [7:0] period;
   logic [7:0] prescale;
   logic       duty_wr;
   logic [2:0] duty_ch;
   logic [7:0] duty_data;
   logic [3:0] invert;
   logic [3:0] pwm_out;
   logic       period_tick;

   int n_cmp;
   int n_bad;

   pwm_multi #(
      .CHANNELS   (4),
      .WIDTH      (8),
      .PRESCALE_W (8),
      .CH_W       (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .center_mode (center_mode),
      .period      (period),
      .prescale    (prescale),
      .duty_wr     (duty_wr),
      .duty_ch     (duty_ch),
      .duty_data   (duty_data),
      .invert      (invert),
      .pwm_out     (pwm_out),
      .period_tick (period_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the period is a phase index k in 0..L-1; the counter
   // value is derived from k (triangle in center mode).
   int unsigned m_pre;
   int          m_k;
   int          m_P;
   bit          m_center;
   int          m_act [4];
   int          m_sh  [4];
   logic [4:0]  q_exp [$];

   function automatic int period_len(input int p, input bit c);
      if (!c) return p + 1;
      return (p == 0) ? 1 : 2 * p;
   endfunction

   function automatic int cnt_of(input int k, input int p, input bit c);
      if (!c) return k;
      return (k <= p) ? k : 2 * p - k;
   endfunction

   always @(posedge clk) begin : model
      int         cnt;
      bit         tk;
      bit         bnd;
      logic [3:0] o;
      if (!rst_n) begin
         m_pre = 0; m_k = 0; m_P = 0; m_center = 1'b0;
         for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_sh[i] = 0; end
         q_exp.push_back(5'b0);
      end else begin
         bnd = 1'b0;
         if (!enable) begin
            o = invert;
            m_pre = 0; m_k = 0;
            m_P = int'(period); m_center = center_mode;
            m_act = m_sh;
         end else begin
            cnt = cnt_of(m_k, m_P, m_center);
            for (int i = 0; i < 4; i++) o[i] = (cnt < m_act[i]) ^ invert[i];
            tk = (m_pre >= int'(prescale));
            m_pre = tk ? 0 : m_pre + 1;
            if (tk) begin
               m_k = (m_k + 1) % period_len(m_P, m_center);
               bnd = (m_k == 0);
            end
            if (bnd) begin
               m_act = m_sh;
               m_P = int'(period); m_center = center_mode;
            end
         end
         if (duty_wr && duty_ch < 3'd4) m_sh[duty_ch] = int'(duty_data);
         q_exp.push_back({bnd, o});
      end
   end

   always @(posedge clk) begin : monitor
      logic [4:0] e;
      #1;
      if (q_exp.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
      end else begin
         e = q_exp.pop_front();
         chk("pwm_out", int'(pwm_out), int'(e[3:0]));
         chk("period_tick", int'(period_tick), int'(e[4]));
      end
   end

   int w_ticks;
   int w_hi [4];

   task automatic count_win(input int n);
      w_ticks = 0;
      for (int i = 0; i < 4; i++) w_hi[i] = 0;
      repeat (n) begin
         @(negedge clk);
         w_ticks += int'(period_tick);
         for (int i = 0; i < 4; i++) w_hi[i] += int'(pwm_out[i]);
      end
   endtask

   task automatic wr(input int ch, input int d);
      duty_wr = 1'b1; duty_ch = 3'(ch); duty_data = 8'(d);
      @(negedge clk);
      duty_wr = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; enable = 1'b0; center_mode = 1'b0; period = 8'd9;
      prescale = 8'd0; duty_wr = 1'b0; duty_ch = 3'd0; duty_data = 8'd0;
      invert = 4'b0;
      step(3);
      rst_n = 1'b1;
      step(2);

      // edge mode and duty extremes
      wr(0, 3); wr(1, 0); wr(2, 10); wr(3, 255);
      enable = 1'b1;
      step(25);
      count_win(100);
      chk("edge_ticks", w_ticks, 10);
      chk("edge_hi0", w_hi[0], 30);
      chk("edge_hi1", w_hi[1], 0);
      chk("edge_hi2", w_hi[2], 100);
      chk("edge_hi3", w_hi[3], 100);
      invert = 4'b0010;
      step(2);
      count_win(20);
      chk("invert_hi1", w_hi[1], 20);
      invert = 4'b0000;

      // double buffering, mid-period write
      step(4);
      wr(0, 7);
      step(30);

      // center mode
      center_mode = 1'b1; period = 8'd4;
      wr(0, 2);
      step(30);
      count_win(80);
      chk("center_ticks", w_ticks, 10);
      chk("center_hi0", w_hi[0], 30);
      period = 8'd0;
      step(20);
      count_win(20);
      chk("p0_ticks", w_ticks, 20);

      // prescaler and out-of-range write
      center_mode = 1'b0; period = 8'd1; prescale = 8'd3;
      step(30);
      count_win(80);
      chk("pre_ticks", w_ticks, 10);
      wr(5, 200);
      step(20);

      // disable mid-period, then re-enable
      invert = 4'b1010;
      step(3);
      enable = 1'b0;
      step(5);
      enable = 1'b1;
      step(20);
      invert = 4'b0000;
      prescale = 8'd0; period = 8'd9;
      step(25);

      // asynchronous reset mid-period
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pwm", int'(pwm_out), 0);
      chk("async_rst_tick", int'(period_tick), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(5);
      count_win(40);
      for (int i = 0; i < 4; i++) chk("post_rst_hi", w_hi[i], 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         duty_wr = ($urandom_range(0, 2) == 0);
         duty_ch = 3'($urandom_range(0, 7));
         duty_data = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 14));
         if ($urandom_range(0, 59) == 0) period = 8'($urandom_range(0, 12));
         if ($urandom_range(0, 79) == 0) prescale = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) center_mode = ~center_mode;
         if ($urandom_range(0, 49) == 0) invert = 4'($urandom);
         if ($urandom_range(0, 149) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         @(negedge clk);
      end
      duty_wr = 1'b0;
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator. It is the next generation of the single-channel 8-bit PWM.
- Shares one prescaled timebase across CHANNELS outputs.
- Timebase has a programmable period, edge-aligned or center-aligned counting, and double-buffered per-channel duty registers that apply only at period boundaries.
- Sits between the CPU-side register interface (write strobe, channel index, data) and the pin outputs for LEDs and motors.

Parameters:
- CHANNELS, 4, number of PWM outputs (≥1).
- WIDTH, 8, counter/period/duty width in bits.
- PRESCALE_W, 8, prescaler compare width in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run; 0 = hold timebase and drive inactive level.
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at boundary.
- period  in  WIDTH  top count P; sampled at boundary.
- prescale  in  PRESCALE_W  tick every prescale+1 clocks; live.
- duty_wr  in  1  write strobe for shadow duty.
- duty_ch  in  max(1,$clog2(CHANNELS))  target channel of the write.
- duty_data  in  WIDTH  duty value D.
- invert  in  CHANNELS  per-channel output polarity; live.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_tick  out  1  one-clock pulse at each period boundary.

Behaviour:
- Reset (rst_n=0, asynchronous) clears to 0: prescaler, counter, direction (up), active/shadow duty, active period, active mode, pwm_out and period_tick.
- Prescaler:
  - Counts 0..prescale; tick=1 on the clock where count==prescale, then count←0.
  - prescale=0 gives a tick every clock.
  - A prescale change while running takes effect at once. If count>prescale, count wraps to 0 and ticks.
- enable=0:
  - Prescaler, counter and direction forced to 0/up.
  - active period/mode/duty continuously loaded from inputs/shadow.
  - period_tick=0; pwm_out←invert.
- enable 0→1: first tick advances counter from 0. The counter=0 state at enable is not a boundary.
- Edge mode:
  - Counter steps 0,1..P on ticks.
  - On a tick with counter==P: counter←0 and a boundary occurs.
  - Period = P+1 ticks.
- Center mode:
  - Counter steps 0..P, then P-1..1, repeat. Period = 2P ticks.
  - Boundary = any tick transition into 0 (from 1 on the down slope, or from P=1).
- P=0 in either mode: counter stays 0 and every tick is a boundary.
- At a boundary, all on the same clock edge:
  - active_duty[i]←shadow[i]
  - active period←period
  - active mode←center_mode
  - period_tick←1 for exactly one clock.
- Compare: raw[i] = (counter < active_duty[i]).
  - pwm_out[i] ← raw[i] ^ invert[i], registered, one-clock latency from counter/duty state.
  - D=0 gives always inactive.
  - D>P gives always active (edge: D=P+1 is also 100%).
  - Active-high time per period: edge = min(D,P+1) ticks; center = 2D-1 ticks for 1≤D≤P.
- Writes:
  - duty_wr=1 loads shadow[duty_ch]←duty_data on that edge.
  - duty_ch ≥ CHANNELS: write ignored.
  - Write on the same edge as a boundary: active takes the pre-write shadow; the new value applies at the next boundary.
- Reset mid-period: outputs go to 0 immediately (asynchronous). After release, behaviour restarts as from power-up.
- All arithmetic is unsigned. No counter width overflow is possible (counter ≤ P ≤ 2^WIDTH-1).

Decomposition:
- Package pwm_pkg:
  - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t
  - default width localparams.
- Sub-module pwm_channel: shadow register, active register, comparator and output flop for one channel. It receives counter, boundary and write-enable. pwm_multi instantiates it CHANNELS times in a generate loop.
- Prescaler and timebase stay in pwm_multi.

Test Plan (CHANNELS=4, WIDTH=8):
1. Edge duty: P=9, prescale=0, write ch0 D=3, enable.
   - After first boundary: pwm_out[0] high 3 clocks, low 7, period_tick every 10 clocks.
2. Extremes: ch1 D=0, ch2 D=10, ch3 D=255, P=9.
   - pwm_out[1] constant 0; pwm_out[2] and pwm_out[3] constant 1 after first boundary.
   - invert[1]=1 makes pwm_out[1] constant 1.
3. Double buffering: mid-period write ch0 D=7 while D=3 is active.
   - Current period still shows 3-high; the next shows 7-high.
   - A write coincident with period_tick appears one period later.
4. Center mode: center_mode=1, P=4, D=2, prescale=0.
   - Period 8 clocks, pwm_out[0] high 3 clocks, period_tick every 8.
   - P=0 gives period_tick every clock.
5. Prescaler: prescale=3, P=1, edge mode.
   - Counter advances every 4 clocks; period_tick every 8 clocks.
   - duty_ch=5 (out of range, with CHANNELS=4 under a 3-bit index build) changes nothing.
6. Control and reset: enable=0 mid-period.
   - Next clock pwm_out=invert, period_tick=0.
   - Re-enable restarts at counter 0.
   - rst_n pulse mid-period gives pwm_out=0 asynchronously and all shadows cleared.
